// File: rtl/jpeg_bitstream_reader.sv
// JPEG entropy-coded segment reader.
// Strips 0xFF00 byte stuffing and discards 0xFF fill bytes. A marker halts
// input until it is acknowledged. An MSB-first bit buffer feeds a 16-bit
// look-ahead window to the Huffman decoder.
module jpeg_bitstream_reader #(
  parameter int BUF_BITS  = 32,
  parameter int PEEK_BITS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           in_byte,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 consume,
  input  logic [4:0]           consume_len,
  input  logic                 align,
  input  logic                 flush,
  output logic [PEEK_BITS-1:0] peek_bits,
  output logic [5:0]           bits_avail,
  output logic                 marker_valid,
  output logic [7:0]           marker_code,
  input  logic                 marker_ack,
  output logic                 underflow
);

  typedef enum logic [1:0] {S_DATA, S_FF, S_MARK} state_t;

  // A byte may only land when a whole byte of room is guaranteed before consume.
  localparam logic [5:0] FILL_MAX = 6'(BUF_BITS - 8);

  state_t              state_q, state_d;
  logic [BUF_BITS-1:0] buf_q;       // oldest bit at MSB, unused low bits kept zero
  logic [5:0]          avail_q;
  logic                mv_q;
  logic [7:0]          mc_q;
  logic                uf_q;

  logic                accept;
  logic                app;
  logic [7:0]          app_byte;
  logic                mk_set;
  logic                mk_clr;

  logic                bad_len;
  logic [BUF_BITS-1:0] buf_c, buf_a, buf_n;
  logic [5:0]          av_c, av_a, av_n;
  logic [2:0]          pad;

  // Input handshake: a consume in the same cycle is deliberately not credited.
  always_comb begin
    in_ready = !reset && !flush && (state_q != S_MARK) && (avail_q <= FILL_MAX);
  end

  assign accept = in_valid && in_ready;

  // Unstuffing FSM: next state plus append/marker decisions.
  always_comb begin
    state_d  = state_q;
    app      = 1'b0;
    app_byte = in_byte;
    mk_set   = 1'b0;
    mk_clr   = 1'b0;
    if (flush) begin
      state_d = S_DATA;
    end else begin
      case (state_q)
        S_DATA: begin
          if (accept) begin
            if (in_byte == 8'hFF) state_d = S_FF;
            else                  app     = 1'b1;
          end
        end
        S_FF: begin
          if (accept) begin
            if (in_byte == 8'h00) begin
              // Stuffed zero: the preceding 0xFF was real data.
              app      = 1'b1;
              app_byte = 8'hFF;
              state_d  = S_DATA;
            end else if (in_byte != 8'hFF) begin
              mk_set  = 1'b1;
              state_d = S_MARK;
            end
          end
        end
        S_MARK: begin
          if (marker_ack) begin
            mk_clr  = 1'b1;
            state_d = S_DATA;
          end
        end
        default: state_d = S_DATA;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_DATA;
    else       state_q <= state_d;
  end

  // Bit buffer next value: consume, then align, then append.
  always_comb begin
    bad_len = consume && (consume_len != 5'd0) &&
              ((consume_len > 5'd16) || ({1'b0, consume_len} > avail_q));
    buf_c = buf_q;
    av_c  = avail_q;
    if (bad_len) begin
      buf_c = '0;
      av_c  = '0;
    end else if (consume) begin
      buf_c = buf_q << consume_len;
      av_c  = avail_q - 6'(consume_len);
    end
    // Whole bytes sit behind a partial head byte, so the head remainder is the pad.
    pad   = align ? av_c[2:0] : 3'd0;
    buf_a = buf_c << pad;
    av_a  = av_c - 6'(pad);
    buf_n = buf_a;
    av_n  = av_a;
    if (app) begin
      buf_n = buf_a | ({app_byte, {(BUF_BITS-8){1'b0}}} >> av_a);
      av_n  = av_a + 6'd8;
    end
  end

  // Buffer, marker and sticky-error registers; flush wins over every strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_q   <= '0;
      avail_q <= '0;
      mv_q    <= 1'b0;
      mc_q    <= 8'h00;
      uf_q    <= 1'b0;
    end else if (flush) begin
      buf_q   <= '0;
      avail_q <= '0;
      mv_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      buf_q   <= buf_n;
      avail_q <= av_n;
      if (mk_set) begin
        mv_q <= 1'b1;
        mc_q <= in_byte;
      end else if (mk_clr) begin
        mv_q <= 1'b0;
      end
      if (bad_len) uf_q <= 1'b1;
    end
  end

  assign peek_bits    = buf_q[BUF_BITS-1 -: PEEK_BITS];
  assign bits_avail   = avail_q;
  assign marker_valid = mv_q;
  assign marker_code  = mc_q;
  assign underflow    = uf_q;

endmodule

// File: tb/tb_jpeg_bitstream_reader.sv
// Bench for jpeg_bitstream_reader: a bit-queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_jpeg_bitstream_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        consume;
  logic [4:0]  consume_len;
  logic        align;
  logic        flush;
  logic [15:0] peek_bits;
  logic [5:0]  bits_avail;
  logic        marker_valid;
  logic [7:0]  marker_code;
  logic        marker_ack;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  jpeg_bitstream_reader #(.BUF_BITS(32), .PEEK_BITS(16)) dut (
    .clock(clock), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .consume(consume), .consume_len(consume_len),
    .align(align), .flush(flush), .peek_bits(peek_bits), .bits_avail(bits_avail),
    .marker_valid(marker_valid), .marker_code(marker_code),
    .marker_ack(marker_ack), .underflow(underflow)
  );

  always #5 clock = ~clock;

  // Model: stream bits as a queue, oldest first.
  bit       mq[$];
  bit       m_ff, m_mark, m_uf;
  bit [7:0] m_code;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic bit [15:0] model_peek();
    bit [15:0] p = '0;
    for (int i = 0; i < 16; i++)
      if (i < mq.size()) p[15-i] = mq[i];
    return p;
  endfunction

  // Model update on each rising edge.
  always @(posedge clock) begin
    bit rdy, acc, was_mark;
    if (reset) begin
      mq.delete(); m_ff = 0; m_mark = 0; m_uf = 0; m_code = 0;
    end else if (flush) begin
      mq.delete(); m_ff = 0; m_mark = 0; m_uf = 0;
    end else begin
      was_mark = m_mark;
      rdy = !m_mark && (mq.size() <= 24);
      acc = in_valid && rdy;
      if (consume && consume_len != 0) begin
        if (consume_len > 16 || consume_len > mq.size()) begin
          m_uf = 1; mq.delete();
        end else begin
          for (int i = 0; i < consume_len; i++) void'(mq.pop_front());
        end
      end
      if (align)
        while (mq.size() % 8 != 0) void'(mq.pop_front());
      if (acc) begin
        if (m_ff) begin
          if (in_byte == 8'h00) begin
            for (int i = 0; i < 8; i++) mq.push_back(1'b1);
            m_ff = 0;
          end else if (in_byte != 8'hFF) begin
            m_code = in_byte; m_mark = 1; m_ff = 0;
          end
        end else if (in_byte == 8'hFF) begin
          m_ff = 1;
        end else begin
          for (int i = 7; i >= 0; i--) mq.push_back(in_byte[i]);
        end
      end
      if (was_mark && marker_ack) m_mark = 0;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clock) begin
    bit exp_rdy;
    exp_rdy = !reset && !flush && !m_mark && (mq.size() <= 24);
    check("in_ready",     32'(in_ready),     32'(exp_rdy));
    check("peek_bits",    32'(peek_bits),    32'(model_peek()));
    check("bits_avail",   32'(bits_avail),   32'(mq.size()));
    check("marker_valid", 32'(marker_valid), 32'(m_mark));
    check("marker_code",  32'(marker_code),  32'(m_code));
    check("underflow",    32'(underflow),    32'(m_uf));
  end

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    #1;
    in_valid = 0; consume = 0; consume_len = 0; align = 0; flush = 0; marker_ack = 0;
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1; in_byte = b;
    step();
  endtask

  task automatic take(input int n);
    consume = 1; consume_len = 5'(n);
    step();
  endtask

  initial begin
    reset = 1; in_byte = 0; in_valid = 0; consume = 0; consume_len = 0;
    align = 0; flush = 0; marker_ack = 0;
    step(); step();
    check("rst_avail", 32'(bits_avail), 0);
    check("rst_peek", 32'(peek_bits), 0);
    check("rst_ready", 32'(in_ready), 0);
    reset = 0; #1;
    check("ready_after_rst", 32'(in_ready), 1);

    // T1
    send(8'hA5); send(8'h3C);
    check("t1_peek", 32'(peek_bits), 32'hA53C);
    check("t1_avail", 32'(bits_avail), 16);
    take(4);
    check("t1_peek2", 32'(peek_bits), 32'h53C0);
    check("t1_avail2", 32'(bits_avail), 12);
    take(12);

    // T2
    send(8'hFF); send(8'h00); send(8'h12);
    check("t2_avail", 32'(bits_avail), 16);
    check("t2_peek", 32'(peek_bits), 32'hFF12);
    take(16);

    // T3
    send(8'h7E); send(8'hFF); send(8'hFF); send(8'hD3);
    check("t3_mv", 32'(marker_valid), 1);
    check("t3_code", 32'(marker_code), 32'hD3);
    check("t3_ready", 32'(in_ready), 0);
    check("t3_peek", 32'(peek_bits), 32'h7E00);
    check("t3_avail", 32'(bits_avail), 8);
    marker_ack = 1; take(8);
    check("t3_avail2", 32'(bits_avail), 0);
    check("t3_mv2", 32'(marker_valid), 0);
    check("t3_ready2", 32'(in_ready), 1);

    // T4
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check("t4_avail", 32'(bits_avail), 32);
    check("t4_ready", 32'(in_ready), 0);
    in_valid = 1; in_byte = 8'h55; consume = 1; consume_len = 8;
    step();
    check("t4_avail2", 32'(bits_avail), 24);
    check("t4_ready2", 32'(in_ready), 1);
    send(8'h55);
    check("t4_avail3", 32'(bits_avail), 32);
    check("t4_peek", 32'(peek_bits), 32'h2233);
    take(16); take(16);

    // T5
    send(8'h81);
    take(9);
    check("t5_uf", 32'(underflow), 1);
    check("t5_avail", 32'(bits_avail), 0);
    flush = 1; step();
    check("t5_uf2", 32'(underflow), 0);

    // T6
    send(8'hAB); send(8'hCD);
    take(3);
    check("t6_avail", 32'(bits_avail), 13);
    align = 1; take(3);
    check("t6_avail2", 32'(bits_avail), 8);
    check("t6_peek", 32'(peek_bits), 32'hCD00);
    consume = 1; consume_len = 0; send(8'hEF);
    check("t6_avail3", 32'(bits_avail), 16);
    check("t6_peek2", 32'(peek_bits), 32'hCDEF);

    // Align on byte boundary is a no-op; len 17 is illegal even with 24 bits held.
    align = 1; step();
    check("align_noop", 32'(bits_avail), 16);
    send(8'h01);
    take(17);
    check("len17_uf", 32'(underflow), 1);
    check("len17_avail", 32'(bits_avail), 0);

    // Flush refuses a same-cycle byte.
    flush = 1; in_valid = 1; in_byte = 8'h42; step();
    check("flush_avail", 32'(bits_avail), 0);
    check("flush_uf", 32'(underflow), 0);

    // Reset discards a pending 0xFF.
    send(8'hFF);
    reset = 1; step();
    reset = 0; #1;
    send(8'h00);
    check("rst_ff_avail", 32'(bits_avail), 8);
    check("rst_ff_peek", 32'(peek_bits), 0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
